// File: rtl/tuple_pack_stage.sv
// Two-entry elastic stage that concatenates (x, y) pairs into one packed tuple.
// Optional STAGE_PACK_COUNT_EN adds a 16-bit output-transfer counter port.
module tuple_pack_stage #(
   parameter int WIDTH_X = 32,
   parameter int WIDTH_Y = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH_X-1:0]         in_x,
   input  logic [WIDTH_Y-1:0]         in_y,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH_X+WIDTH_Y-1:0] out_data
`ifdef STAGE_PACK_COUNT_EN
   ,
   output logic [15:0]                xfer_count
`endif
);

   localparam int WIDTH_T = WIDTH_X + WIDTH_Y;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH_T-1:0]   main_q, main_d;
   logic [WIDTH_T-1:0]   skid_q, skid_d;
   logic [WIDTH_T-1:0]   pair;
   logic                 in_fire;
   logic                 out_fire;

   // y occupies the upper field, x the lower; no arithmetic on either.
   assign pair      = {in_y, in_x};
   // Ready is a pure state decode, additionally held low while reset is asserted.
   assign in_ready  = ~rst & (state_q != ST_TWO);
   assign out_valid = (state_q != ST_EMPTY);
   assign out_data  = main_q;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (in_fire) begin
               main_d  = pair;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (in_fire && out_fire) begin
               main_d = pair;
            end else if (in_fire) begin
               skid_d  = pair;
               state_d = ST_TWO;
            end else if (out_fire) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (out_fire) begin
               main_d  = skid_q;
               state_d = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

`ifdef STAGE_PACK_COUNT_EN
   logic [15:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (out_fire) count_d = count_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign xfer_count = count_q;
`else
   // Counter omitted: no extra state or port in this build.
`endif

endmodule

// File: doc/tuple_pack_stage.md
TUPLE_PACK_STAGE -- requirements
Module: tuple_pack_stage

Interface
REQ-001 Parameter WIDTH_X, default 32, bit width of tuple element x.
REQ-002 Parameter WIDTH_Y, default 32, bit width of tuple element y.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  producer asserts when in_x/in_y hold a valid element pair.
REQ-006 in_ready  output  1  block can accept a pair this cycle.
REQ-007 in_x  input  WIDTH_X  tuple element x.
REQ-008 in_y  input  WIDTH_Y  tuple element y.
REQ-009 out_valid  output  1  out_data holds a packed tuple.
REQ-010 out_ready  input  1  consumer accepts out_data this cycle.
REQ-011 out_data  output  WIDTH_X+WIDTH_Y  packed tuple: x in [WIDTH_X-1:0], y in [WIDTH_X+WIDTH_Y-1:WIDTH_X].
REQ-012 xfer_count  output  16  output-transfer counter; present only with STAGE_PACK_COUNT_EN.

Function
REQ-013 Input fire = in_valid & in_ready; output fire = out_valid & out_ready, both sampled at posedge clk.
REQ-014 Packing SHALL be pure concatenation, no arithmetic, sign extension or truncation; bit layout exactly per REQ-011, matching the stitch unpacker field slicing.
REQ-015 Storage SHALL be a main register driving out_data plus one skid register; occupancy state EMPTY(0), ONE(1), TWO(2).
REQ-016 in_ready SHALL be a registered-state decode: 1 in EMPTY and ONE, 0 in TWO; it SHALL NOT depend combinationally on out_ready.
REQ-017 out_valid SHALL be 1 in ONE and TWO, 0 in EMPTY.
REQ-018 EMPTY: input fire -> main loads pair, next ONE; else stay.
REQ-019 ONE: input fire and output fire -> main loads new pair, stay ONE; input fire only -> skid loads pair, next TWO; output fire only -> next EMPTY; neither -> stay.
REQ-020 TWO: output fire -> main loads skid contents, next ONE; else stay; input fire impossible.
REQ-021 Latency: pair accepted at edge N SHALL be on out_data with out_valid=1 in the cycle after edge N; sustained throughput one tuple per cycle when out_ready=1.
REQ-022 Order SHALL be preserved; no tuple dropped or duplicated under any in_valid/out_ready pattern.
REQ-023 While out_valid=1 and out_ready=0, out_data SHALL remain stable.
REQ-024 out_data in EMPTY SHALL retain last value (don't-care to consumers); after reset it is 0.

Reset
REQ-025 rst assertion SHALL immediately, without clock, force state EMPTY, out_valid=0, out_data=0, skid=0, xfer_count=0.
REQ-026 in_ready SHALL be 0 while rst is high and 1 in the first cycle after deassertion.
REQ-027 Reset mid-operation SHALL discard all held tuples; no tuple accepted before reset appears afterward.

Configuration
REQ-028 Macro STAGE_PACK_COUNT_EN defined: xfer_count increments by 1 on each output fire, wraps 0xFFFF->0x0000, holds otherwise.
REQ-029 Macro undefined: xfer_count port and counter logic absent; all other behaviour identical.

Verification
REQ-030 Reset release, in_x=0x40, in_y=0x2a, in_valid one cycle, out_ready=1 -> next cycle out_valid=1, out_data=0x0000002a_00000040, then out_valid=0.
REQ-031 out_ready=0, offer pairs A,B,C back-to-back -> A,B accepted, in_ready=0 after B, C held; raise out_ready -> out_data A,B,C in order on consecutive cycles.
REQ-032 State ONE, in_valid=1 and out_ready=1 for 8 cycles with x=0..7 -> 8 tuples out, in_ready never drops, one per cycle.
REQ-033 State TWO, assert rst asynchronously between edges -> out_valid=0 and out_data=0 immediately; after release, no stale tuple emitted.
REQ-034 STAGE_PACK_COUNT_EN, 65537 output transfers -> xfer_count=0x0001; without macro, same stimulus passes REQ-030..033 unchanged.
